// File: rtl/param_channel_select_if.sv
// ============================================================================
//  Module   : param_channel_select_if
//  Brief    : Input/output handshake bundle for param_channel_select.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface param_channel_select_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 9,
    parameter int SEL_W  = 4
);
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    sel_err;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_sel, sel_err, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_sel, sel_err, out_valid
    );
endinterface

`default_nettype wire

// File: rtl/param_channel_select.sv
// ============================================================================
//  Module   : param_channel_select
//  Brief    : Registered N-to-1 channel select with a two-entry skid buffer.
//             Define CHSEL_ERR_CNT_EN to add err_clr / err_cnt (bad-select count).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module param_channel_select #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 9,
    parameter int SEL_W  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    param_channel_select_if.slave       bus
`ifdef CHSEL_ERR_CNT_EN
    ,
    input  logic                        err_clr,
    output logic [15:0]                 err_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_in_ready;

    logic [WIDTH-1:0]   r_main_data;
    logic [SEL_W-1:0]   r_main_sel;
    logic               r_main_err;
    logic [WIDTH-1:0]   r_skid_data;
    logic [SEL_W-1:0]   r_skid_sel;
    logic               r_skid_err;

    logic               w_accept;
    logic               w_xfer;
    logic               w_out_valid;
    logic               w_sel_err;
    logic [WIDTH-1:0]   w_sel_data;
    logic               w_load_main;
    logic               w_load_skid;
    logic               w_skid_to_main;

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_accept    = bus.in_valid & r_in_ready;
    assign w_xfer      = w_out_valid & bus.out_ready;

    // Out-of-range selects produce zero data and raise the error flag.
    always_comb begin
        w_sel_err  = (int'(bus.in_sel) >= NUM_CH);
        w_sel_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(bus.in_sel) == k) begin
                w_sel_data = bus.in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_next      = ST_ONE;
                    w_load_main = 1'b1;
                end
            end
            ST_ONE: begin
                case ({w_accept, w_xfer})
                    2'b11: w_load_main = 1'b1;
                    2'b10: begin
                        w_next      = ST_TWO;
                        w_load_skid = 1'b1;
                    end
                    2'b01: w_next = ST_EMPTY;
                    default: w_next = ST_ONE;
                endcase
            end
            ST_TWO: begin
                if (w_xfer) begin
                    w_next         = ST_ONE;
                    w_skid_to_main = 1'b1;
                end
            end
            default: w_next = ST_EMPTY;
        endcase
    end

    // in_ready is registered from the next state, so out_ready never reaches it combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next != ST_TWO);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_data <= '0;
            r_main_sel  <= '0;
            r_main_err  <= 1'b0;
            r_skid_data <= '0;
            r_skid_sel  <= '0;
            r_skid_err  <= 1'b0;
        end else begin
            if (w_load_main) begin
                r_main_data <= w_sel_data;
                r_main_sel  <= bus.in_sel;
                r_main_err  <= w_sel_err;
            end else if (w_skid_to_main) begin
                r_main_data <= r_skid_data;
                r_main_sel  <= r_skid_sel;
                r_main_err  <= r_skid_err;
            end
            if (w_load_skid) begin
                r_skid_data <= w_sel_data;
                r_skid_sel  <= bus.in_sel;
                r_skid_err  <= w_sel_err;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_main_data;
    assign bus.out_sel   = r_main_sel;
    assign bus.sel_err   = r_main_err;

`ifdef CHSEL_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    // Clear takes priority over a same-cycle increment; the count saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (err_clr) begin
            r_err_cnt <= '0;
        end else if (w_accept && w_sel_err && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_param_channel_select.sv
// ============================================================================
//  Module   : tb_param_channel_select
//  Brief    : Self-checking bench for param_channel_select against a queue model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_param_channel_select;

    localparam int WIDTH  = 32;
    localparam int NUM_CH = 9;
    localparam int SEL_W  = 4;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [SEL_W-1:0] s;
        logic             e;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    param_channel_select_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) bus ();

    logic [WIDTH-1:0] chan [NUM_CH];

    always_comb begin
        bus.in_data = '0;
        for (int k = 0; k < NUM_CH; k++) bus.in_data[k*WIDTH +: WIDTH] = chan[k];
    end

`ifdef CHSEL_ERR_CNT_EN
    logic        err_clr = 1'b0;
    logic [15:0] err_cnt;
`endif

    param_channel_select #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave)
`ifdef CHSEL_ERR_CNT_EN
        ,
        .err_clr (err_clr),
        .err_cnt (err_cnt)
`endif
    );

    // Reference model: FIFO of accepted beats, capacity two.
    beat_t q[$];
    bit    fresh = 1'b1;
    int    n_chk = 0;
    int    n_err = 0;
    int    n_acc = 0;
    int    ecnt  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("in_ready", 64'(bus.in_ready), 64'(!fresh && q.size() < 2));
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_data", 64'(bus.out_data), 64'(q[0].d));
            chk("out_sel", 64'(bus.out_sel), 64'(q[0].s));
            chk("sel_err", 64'(bus.sel_err), 64'(q[0].e));
        end
`ifdef CHSEL_ERR_CNT_EN
        chk("err_cnt", 64'(err_cnt), 64'(ecnt));
`endif
    endtask

    task automatic cycle();
        bit    acc, xf;
        beat_t b;
        @(negedge clk);
        check_outputs();
        acc = bus.in_valid && bus.in_ready;
        xf  = bus.out_valid && bus.out_ready;
        b.s = bus.in_sel;
        b.e = (int'(bus.in_sel) >= NUM_CH);
        b.d = b.e ? '0 : chan[int'(bus.in_sel)];
        @(posedge clk);
        if (rst) begin
            q.delete();
            fresh = 1'b1;
            ecnt  = 0;
        end else begin
            if (xf && q.size() > 0) void'(q.pop_front());
            if (acc) begin
                q.push_back(b);
                n_acc++;
            end
            fresh = 1'b0;
`ifdef CHSEL_ERR_CNT_EN
            if (err_clr) ecnt = 0;
            else if (acc && b.e && ecnt < 65535) ecnt++;
`endif
        end
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_out_data"}, 64'(bus.out_data), 64'd0);
        chk({tag, "_out_sel"}, 64'(bus.out_sel), 64'd0);
        chk({tag, "_sel_err"}, 64'(bus.sel_err), 64'd0);
    endtask

    initial begin
        int guard;
        bus.in_valid  = 1'b0;
        bus.in_sel    = '0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < NUM_CH; k++) chan[k] = 32'h1000_0000 + k;

        // Reset state
        cycle();
        cycle();
        check_zero_outputs("reset");
        rst = 1'b0;
        cycle();
        chk("ready_after_release", 64'(bus.in_ready), 64'd1);

        // Single good beat on channel 3
        chan[3]       = 32'hA5A5A5A5;
        bus.in_sel    = 4'd3;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        cycle();
        chk("beat3_valid", 64'(bus.out_valid), 64'd1);
        chk("beat3_data", 64'(bus.out_data), 64'hA5A5A5A5);
        chk("beat3_sel", 64'(bus.out_sel), 64'd3);
        chk("beat3_err", 64'(bus.sel_err), 64'd0);

        // Out-of-range select
        bus.in_sel = 4'd12;
        cycle();
        bus.in_valid = 1'b0;
        chk("bad_data", 64'(bus.out_data), 64'd0);
        chk("bad_err", 64'(bus.sel_err), 64'd1);
        chk("bad_sel", 64'(bus.out_sel), 64'd12);
`ifdef CHSEL_ERR_CNT_EN
        chk("bad_errcnt", 64'(err_cnt), 64'd1);
`endif
        cycle();

        // Backpressure fills both entries
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_sel = SEL_W'(i + 1);
            cycle();
        end
        chk("bp_ready_low", 64'(bus.in_ready), 64'd0);
        chk("bp_depth", 64'(q.size()), 64'd2);
        bus.out_ready = 1'b1;
        cycle();
        chk("bp_ready_back", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < 3; i++) cycle();

        // Random stream against the model
        guard = 0;
        n_acc = 0;
        while (n_acc < 100 && guard < 3000) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_sel    = SEL_W'($urandom_range(0, 15));
            bus.out_ready = $urandom_range(0, 1) != 0;
            for (int k = 0; k < NUM_CH; k++) chan[k] = $urandom;
            cycle();
            guard++;
        end
        chk("stream_accepts", 64'(n_acc >= 100), 64'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        chk("stream_drained", 64'(q.size()), 64'd0);

        // Asynchronous reset while two beats are held
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 4'd5;
        cycle();
        cycle();
        chk("pre_rst_depth", 64'(q.size()), 64'd2);
        rst = 1'b1;
        #1;
        check_zero_outputs("async_rst");
        q.delete();
        fresh = 1'b1;
        ecnt  = 0;
        bus.in_valid = 1'b0;
        cycle();
        rst = 1'b0;
        cycle();
        chk("ready_after_rst", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        cycle();

`ifdef CHSEL_ERR_CNT_EN
        // Saturation and clear priority
        bus.in_valid  = 1'b1;
        bus.in_sel    = 4'd15;
        bus.out_ready = 1'b1;
        guard = 0;
        while (ecnt < 65535 && guard < 70000) begin
            cycle();
            guard++;
        end
        chk("sat_reached", 64'(err_cnt), 64'hFFFF);
        cycle();
        chk("sat_hold", 64'(err_cnt), 64'hFFFF);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        chk("clr_wins", 64'(err_cnt), 64'd0);
        bus.in_valid = 1'b0;
        cycle();
        cycle();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
